mult_elastic_pipe: RTL and testbench
====================================

Name: mult_elastic_pipe

Overview:
- Parametrised, elastic multiplier-pipeline register chain; replaces the fixed per-stage mult latches between multiplier issue and integer writeback.
- Carries writeback payload (data, dest addr, write enable, instruction, pc) through STAGES registers.
- Adds per-stage valid, ready/valid backpressure with bubble collapse, global kill, occupancy count, and two destination-hazard query ports for the decode scoreboard.

Parameters:
STAGES, 5, number of register stages (>=1)
DATA_W, 32, writeback data width
ADDR_W, 5, register-file address width
PC_W, 32, pc and instruction width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
kill_i  in  1  synchronous flush of all stages
in_valid_i  in  1  upstream payload valid
in_data_i  in  DATA_W  write data
in_addr_i  in  ADDR_W  destination register
in_we_i  in  1  integer write enable
in_instr_i  in  PC_W  instruction
in_pc_i  in  PC_W  pc
in_ready_o  out  1  stage 0 can accept this cycle
out_valid_o  out  1  last stage holds valid entry
out_data_o / out_addr_o / out_we_o / out_instr_o / out_pc_o  out  DATA_W/ADDR_W/1/PC_W/PC_W  last-stage payload
out_ready_i  in  1  writeback accepts last stage
query_a_i, query_b_i  in  ADDR_W  source registers to check
hit_a_o, hit_b_o  out  1  pending write to queried register
occupancy_o  out  $clog2(STAGES+1)  count of valid stages

Behaviour:
- Reset (async, rst_i=1): all valid bits 0, all payload registers 0; hence out_valid_o=0, all out_* = 0, hit_*=0, occupancy_o=0, in_ready_o=1.
- Stage k advance: adv[k] = v[k] && ready[k+1]; ready[k] = !v[k] || adv[k]; ready[STAGES] = out_ready_i. Combinational ready chain, no registered skid.
- Load: stage k loads from stage k-1 (stage 0 from in_*) when ready[k] and upstream valid; v[k] <= upstream valid && ready[k]. Stage left empty after its entry departs clears v[k]; payload is cleared to 0 when v[k] falls.
- Bubbles collapse: an empty stage always accepts, even when downstream is stalled.
- Latency: STAGES cycles input-to-output with out_ready_i held 1; throughput 1/cycle.
- out_we_o = v[last] && we[last]; out_* payload meaningful only when out_valid_o.
- Kill: kill_i=1 at an edge clears all v[] and payload to 0; incoming in_valid_i that cycle is dropped; kill overrides advance/load. in_ready_o is unaffected by kill (combinational on current state).
- Hazard: hit_x_o = OR over stages of (v[k] && we[k] && addr[k]==query_x_i && query_x_i!=0). Combinational, covers all stages including last.
- occupancy_o = popcount(v[]), registered-state derived, range 0..STAGES.
- Full: all v=1 and out_ready_i=0 -> in_ready_o=0, no stage changes.
- Simultaneous full and out_ready_i=1: whole chain shifts, in_ready_o=1 same cycle.
- Reset mid-operation: asynchronous clear regardless of kill/handshake; first accept on first edge after rst_i deasserts.
- STAGES=1: single elastic register, same rules.

Decomposition:
- Shared package mult_pkg: payload struct typedef (data, addr, we, instr, pc) parameterised by widths via localparams DATA_W/ADDR_W/PC_W defaults; occupancy width function.
- Sub-module mult_pipe_stage: one valid+payload register with ready computation; top instantiates STAGES copies via generate and ORs hazard/popcount.

Test Plan:
- Stream 8 entries pc=0x100..0x11C, out_ready_i=1 -> first out_valid_o 5 cycles after first accept, pcs in order, one per cycle, occupancy_o steady at 5.
- Fill with out_ready_i=0, 6 inputs -> 5 accepted, in_ready_o=0 on 6th, occupancy_o=5; raise out_ready_i -> in_ready_o=1 same cycle, 6th accepted.
- Insert entry then 3 idle cycles, stall out_ready_i=0, send 2nd entry -> 2nd collapses to stage 3 (adjacent to 1st), occupancy_o=2.
- Entry addr=7 we=1 in flight, query_a_i=7 -> hit_a_o=1 each cycle until out accepted; query_b_i=0 with addr=0 entry -> hit_b_o=0; we=0 entry addr=7 -> no hit.
- Full pipe, kill_i=1 with in_valid_i=1 -> next cycle occupancy_o=0, out_valid_o=0, out_* = 0, killed input never emerges.
- Assert rst_i asynchronously between edges with 3 valid entries -> outputs 0 immediately; deassert, send pc=0x200 -> emerges after 5 cycles.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the elastic multiplier writeback pipe.
// Holds the default payload widths, the payload struct at those widths,
// and width helpers used to size the flat per-stage payload and occupancy.
package mult_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned PC_W   = 32;

    // Writeback payload at default widths; field order matches the flat stage vector.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [PC_W-1:0]   instr;
        logic [PC_W-1:0]   pc;
    } mult_payload_t;

    // Bits needed to count 0..stages valid entries.
    function automatic int unsigned occ_w(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

    // Flat payload width for arbitrary field widths.
    function automatic int unsigned payload_w(input int unsigned dw,
                                              input int unsigned aw,
                                              input int unsigned pw);
        return dw + aw + 1 + 2 * pw;
    endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One elastic pipe stage: valid bit plus payload register.
// Ports:
//   clk_i, rst_i    clock, async active-high reset
//   kill_i          synchronous flush of this stage
//   up_valid_i      upstream entry valid
//   up_payload_i    upstream payload
//   dn_ready_i      downstream can take this stage's entry
//   up_ready_c      combinational: this stage can load this cycle
//   valid_o         stage holds a valid entry
//   payload_o       stage payload (zero when empty)
module mult_pipe_stage #(
    parameter int unsigned PW = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          kill_i,
    input  logic          up_valid_i,
    input  logic [PW-1:0] up_payload_i,
    input  logic          dn_ready_i,
    output logic          up_ready_c,
    output logic          valid_o,
    output logic [PW-1:0] payload_o
);

    logic          v_q, v_d;
    logic [PW-1:0] p_q, p_d;

    // Empty stage always accepts, so bubbles collapse under a downstream stall.
    assign up_ready_c = !v_q || dn_ready_i;

    // Next state: kill wins; otherwise load when ready, clearing payload when emptied.
    always_comb begin
        v_d = v_q;
        p_d = p_q;
        if (kill_i) begin
            v_d = 1'b0;
            p_d = '0;
        end else if (up_ready_c) begin
            v_d = up_valid_i;
            p_d = up_valid_i ? up_payload_i : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q <= 1'b0;
            p_q <= '0;
        end else begin
            v_q <= v_d;
            p_q <= p_d;
        end
    end

    assign valid_o   = v_q;
    assign payload_o = p_q;

endmodule

// File: rtl/mult_elastic_pipe.sv
// Elastic register chain carrying multiplier writeback payload to integer writeback.
// Ports:
//   clk_i, rst_i, kill_i          clock, async active-high reset, sync flush
//   in_valid_i/in_*_i/in_ready_o  upstream ready/valid handshake and payload
//   out_valid_o/out_*_o/out_ready_i  last-stage payload and writeback handshake
//   query_a_i/query_b_i, hit_a_o/hit_b_o  destination-hazard queries (combinational)
//   occupancy_o                   number of valid stages
module mult_elastic_pipe
    import mult_pkg::occ_w, mult_pkg::payload_w;
#(
    parameter  int unsigned STAGES = 5,
    parameter  int unsigned DATA_W = mult_pkg::DATA_W,
    parameter  int unsigned ADDR_W = mult_pkg::ADDR_W,
    parameter  int unsigned PC_W   = mult_pkg::PC_W,
    localparam int unsigned OCC_W  = occ_w(STAGES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              kill_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic              in_we_i,
    input  logic [PC_W-1:0]   in_instr_i,
    input  logic [PC_W-1:0]   in_pc_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_we_o,
    output logic [PC_W-1:0]   out_instr_o,
    output logic [PC_W-1:0]   out_pc_o,
    input  logic              out_ready_i,
    input  logic [ADDR_W-1:0] query_a_i,
    input  logic [ADDR_W-1:0] query_b_i,
    output logic              hit_a_o,
    output logic              hit_b_o,
    output logic [OCC_W-1:0]  occupancy_o
);

    // Flat payload layout: {data, addr, we, instr, pc}, pc in the LSBs.
    localparam int unsigned PW       = payload_w(DATA_W, ADDR_W, PC_W);
    localparam int unsigned INSTR_LO = PC_W;
    localparam int unsigned WE_B     = 2 * PC_W;
    localparam int unsigned ADDR_LO  = WE_B + 1;
    localparam int unsigned DATA_LO  = ADDR_LO + ADDR_W;
    localparam int unsigned LAST     = STAGES - 1;

    logic [STAGES:0]   rdy_c;
    logic [STAGES-1:0] v;
    logic [PW-1:0]     pay [STAGES];
    logic [PW-1:0]     in_payload;
    logic              hit_a_c, hit_b_c;
    logic [OCC_W-1:0]  occ_c;

    assign in_payload    = {in_data_i, in_addr_i, in_we_i, in_instr_i, in_pc_i};
    assign rdy_c[STAGES] = out_ready_i;

    // Stage chain; ready ripples combinationally from writeback back to stage 0.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic          up_v;
        logic [PW-1:0] up_p;
        if (k == 0) begin : g_head
            assign up_v = in_valid_i;
            assign up_p = in_payload;
        end else begin : g_body
            assign up_v = v[k-1];
            assign up_p = pay[k-1];
        end

        mult_pipe_stage #(.PW(PW)) u_stage (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .kill_i       (kill_i),
            .up_valid_i   (up_v),
            .up_payload_i (up_p),
            .dn_ready_i   (rdy_c[k+1]),
            .up_ready_c   (rdy_c[k]),
            .valid_o      (v[k]),
            .payload_o    (pay[k])
        );
    end

    // Hazard lookup over every stage; register 0 never reports a hazard.
    always_comb begin
        hit_a_c = 1'b0;
        hit_b_c = 1'b0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (v[k] && pay[k][WE_B]) begin
                if (pay[k][ADDR_LO +: ADDR_W] == query_a_i && query_a_i != '0) hit_a_c = 1'b1;
                if (pay[k][ADDR_LO +: ADDR_W] == query_b_i && query_b_i != '0) hit_b_c = 1'b1;
            end
        end
    end

    // Popcount of stage valids.
    always_comb begin
        occ_c = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            occ_c = occ_c + OCC_W'(v[k]);
        end
    end

    assign in_ready_o  = rdy_c[0];
    assign out_valid_o = v[LAST];
    assign out_data_o  = pay[LAST][DATA_LO +: DATA_W];
    assign out_addr_o  = pay[LAST][ADDR_LO +: ADDR_W];
    assign out_we_o    = v[LAST] && pay[LAST][WE_B];
    assign out_instr_o = pay[LAST][INSTR_LO +: PC_W];
    assign out_pc_o    = pay[LAST][PC_W-1:0];
    assign hit_a_o     = hit_a_c;
    assign hit_b_o     = hit_b_c;
    assign occupancy_o = occ_c;

endmodule

// File: tb/tb_mult_elastic_pipe.sv
// Directed bench for mult_elastic_pipe (STAGES=5): streaming, fill/stall,
// bubble collapse, hazard queries, kill and asynchronous reset.
module tb_mult_elastic_pipe;
    import mult_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        kill_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic [31:0] in_data_i = '0;
    logic [4:0]  in_addr_i = '0;
    logic        in_we_i = 1'b0;
    logic [31:0] in_instr_i = '0;
    logic [31:0] in_pc_i = '0;
    logic        in_ready_o;
    logic        out_valid_o;
    logic [31:0] out_data_o;
    logic [4:0]  out_addr_o;
    logic        out_we_o;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;
    logic        out_ready_i = 1'b0;
    logic [4:0]  query_a_i = '0;
    logic [4:0]  query_b_i = '0;
    logic        hit_a_o, hit_b_o;
    logic [2:0]  occupancy_o;

    int n_cmp = 0;
    int n_err = 0;

    mult_elastic_pipe #(.STAGES(5)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .kill_i      (kill_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_addr_i   (in_addr_i),
        .in_we_i     (in_we_i),
        .in_instr_i  (in_instr_i),
        .in_pc_i     (in_pc_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_addr_o  (out_addr_o),
        .out_we_o    (out_we_o),
        .out_instr_o (out_instr_o),
        .out_pc_o    (out_pc_o),
        .out_ready_i (out_ready_i),
        .query_a_i   (query_a_i),
        .query_b_i   (query_b_i),
        .hit_a_o     (hit_a_o),
        .hit_b_o     (hit_b_o),
        .occupancy_o (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp_v, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] addr, input logic we);
        mult_payload_t p;
        p.pc    = pc;
        p.instr = ~pc;
        p.we    = we;
        p.addr  = addr;
        p.data  = pc + 32'h1000_0000;
        in_valid_i = v;
        in_pc_i    = p.pc;
        in_instr_i = p.instr;
        in_we_i    = p.we;
        in_addr_i  = p.addr;
        in_data_i  = p.data;
    endtask

    initial begin
        int acc, dep;

        // Reset state
        step();
        check_eq("rst_out_valid", 64'(out_valid_o), 64'd0);
        check_eq("rst_occ", 64'(occupancy_o), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready_o), 64'd1);
        check_eq("rst_out_pc", 64'(out_pc_o), 64'd0);
        check_eq("rst_hit_a", 64'(hit_a_o), 64'd0);
        rst_i = 1'b0;
        step();

        // Stream 8 entries with writeback always ready
        out_ready_i = 1'b1;
        for (int c = 0; c < 13; c++) begin
            if (c < 8) drive(1'b1, 32'h100 + 32'(4 * c), 5'd1, 1'b1);
            else       drive(1'b0, 32'h0, 5'd0, 1'b0);
            step();
            acc = (c + 1 < 8) ? c + 1 : 8;
            dep = (c - 4 < 0) ? 0 : ((c - 4 > 8) ? 8 : c - 4);
            check_eq("stream_valid", 64'(out_valid_o), 64'(c >= 4 && c <= 11));
            check_eq("stream_occ", 64'(occupancy_o), 64'(acc - dep));
            if (c >= 4 && c <= 11) begin
                check_eq("stream_pc", 64'(out_pc_o), 64'(32'h100 + 32'(4 * (c - 4))));
                check_eq("stream_data", 64'(out_data_o), 64'(32'h1000_0100 + 32'(4 * (c - 4))));
            end
        end

        // Fill with writeback stalled, then release
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h300 + 32'(i), 5'd2, 1'b1);
            #1;
            check_eq("fill_in_ready", 64'(in_ready_o), 64'd1);
            step();
        end
        drive(1'b1, 32'h305, 5'd2, 1'b1);
        #1;
        check_eq("full_in_ready", 64'(in_ready_o), 64'd0);
        check_eq("full_occ", 64'(occupancy_o), 64'd5);
        step();
        check_eq("full_hold_occ", 64'(occupancy_o), 64'd5);
        check_eq("full_hold_pc", 64'(out_pc_o), 64'h300);
        out_ready_i = 1'b1;
        #1;
        check_eq("release_in_ready", 64'(in_ready_o), 64'd1);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        check_eq("release_occ", 64'(occupancy_o), 64'd5);
        check_eq("release_pc", 64'(out_pc_o), 64'h301);
        for (int i = 2; i < 6; i++) begin
            step();
            check_eq("drain_pc", 64'(out_pc_o), 64'(32'h300 + 32'(i)));
        end
        step();
        check_eq("drain_empty", 64'(occupancy_o), 64'd0);

        // Bubble collapse: second entry closes up behind a stalled first entry
        drive(1'b1, 32'h400, 5'd3, 1'b1);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        step(); step(); step();
        out_ready_i = 1'b0;
        drive(1'b1, 32'h404, 5'd3, 1'b1);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        step(); step(); step();
        check_eq("bubble_occ", 64'(occupancy_o), 64'd2);
        check_eq("bubble_head_pc", 64'(out_pc_o), 64'h400);
        out_ready_i = 1'b1;
        step();
        check_eq("bubble_adjacent_valid", 64'(out_valid_o), 64'd1);
        check_eq("bubble_adjacent_pc", 64'(out_pc_o), 64'h404);
        step();
        check_eq("bubble_drained", 64'(occupancy_o), 64'd0);

        // Hazard queries
        query_a_i = 5'd7;
        query_b_i = 5'd0;
        drive(1'b1, 32'h500, 5'd7, 1'b1);
        #1;
        check_eq("hit_a_empty", 64'(hit_a_o), 64'd0);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("hit_a_inflight", 64'(hit_a_o), 64'd1);
            if (i == 4) check_eq("hit_out_we", 64'(out_we_o), 64'd1);
            step();
        end
        check_eq("hit_a_gone", 64'(hit_a_o), 64'd0);
        drive(1'b1, 32'h510, 5'd0, 1'b1);
        step();
        drive(1'b1, 32'h514, 5'd7, 1'b0);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        #1;
        check_eq("hit_a_we0", 64'(hit_a_o), 64'd0);
        check_eq("hit_b_r0", 64'(hit_b_o), 64'd0);
        step(); step(); step();
        check_eq("r0_out_pc", 64'(out_pc_o), 64'h510);
        check_eq("r0_out_we", 64'(out_we_o), 64'd1);
        step();
        check_eq("we0_out_pc", 64'(out_pc_o), 64'h514);
        check_eq("we0_out_we", 64'(out_we_o), 64'd0);
        step();
        query_a_i = 5'd0;

        // Kill a full pipe with a concurrent input
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h600 + 32'(4 * i), 5'd3, 1'b1);
            step();
        end
        drive(1'b1, 32'h6FC, 5'd3, 1'b1);
        kill_i = 1'b1;
        #1;
        check_eq("kill_in_ready", 64'(in_ready_o), 64'd0);
        step();
        kill_i = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        check_eq("kill_occ", 64'(occupancy_o), 64'd0);
        check_eq("kill_out_valid", 64'(out_valid_o), 64'd0);
        check_eq("kill_out_pc", 64'(out_pc_o), 64'd0);
        check_eq("kill_out_data", 64'(out_data_o), 64'd0);
        check_eq("kill_out_addr", 64'(out_addr_o), 64'd0);
        out_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("kill_no_emerge", 64'(out_valid_o), 64'd0);
        end

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h700 + 32'(4 * i), 5'd9, 1'b1);
            step();
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        out_ready_i = 1'b0;
        query_a_i = 5'd9;
        #1;
        check_eq("pre_rst_hit", 64'(hit_a_o), 64'd1);
        check_eq("pre_rst_occ", 64'(occupancy_o), 64'd3);
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("async_rst_occ", 64'(occupancy_o), 64'd0);
        check_eq("async_rst_hit", 64'(hit_a_o), 64'd0);
        check_eq("async_rst_in_ready", 64'(in_ready_o), 64'd1);
        check_eq("async_rst_pc", 64'(out_pc_o), 64'd0);
        #2;
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        drive(1'b1, 32'h200, 5'd4, 1'b1);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("post_rst_not_yet", 64'(out_valid_o), 64'd0);
        end
        step();
        check_eq("post_rst_valid", 64'(out_valid_o), 64'd1);
        check_eq("post_rst_pc", 64'(out_pc_o), 64'h200);
        step();
        check_eq("post_rst_empty", 64'(occupancy_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
